// File: rtl/key_sched_if.sv
// Key-expansion port bundle: key load, rcon ROM, SubWord unit and round-key store.
// Optional KEY_SCHED_LAST_KEY_EN adds the last_key output.
interface key_sched_if;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic [3:0]   rcon_addr;
    logic [31:0]  rcon_dout;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic         rk_we;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
`ifdef KEY_SCHED_LAST_KEY_EN
    logic [127:0] last_key;

    modport master (
        output start, key_in, rcon_dout, sub_out,
        input  busy, done, rcon_addr, sub_in, rk_we, rk_addr, rk_data, last_key
    );

    modport slave (
        input  start, key_in, rcon_dout, sub_out,
        output busy, done, rcon_addr, sub_in, rk_we, rk_addr, rk_data, last_key
    );
`else
    modport master (
        output start, key_in, rcon_dout, sub_out,
        input  busy, done, rcon_addr, sub_in, rk_we, rk_addr, rk_data
    );

    modport slave (
        input  start, key_in, rcon_dout, sub_out,
        output busy, done, rcon_addr, sub_in, rk_we, rk_addr, rk_data
    );
`endif
endinterface

// File: rtl/key_sched_ctrl.sv
// AES-128 key-expansion sequencer driving external registered rcon ROM and SubWord unit.
// Define KEY_SCHED_LAST_KEY_EN to add the last_key register/output.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start; key captured on acceptance
// S_LOAD  | write cipher key as round key 0
// S_FETCH | rcon_addr / sub_in presented (registered on entry)
// S_CALC  | ROM data valid; compute and write round key `round`
// S_DONE  | one-cycle done pulse
module key_sched_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    key_sched_if.slave ks
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FETCH = 3'd2,
        S_CALC  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    state_t       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] wkey_q, wkey_d;
    logic [3:0]   rcon_addr_q, rcon_addr_d;
    logic [31:0]  sub_in_q, sub_in_d;
    logic [127:0] next_key;
    logic [31:0]  t_word;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;
`ifdef KEY_SCHED_LAST_KEY_EN
    logic [127:0] last_key_q, last_key_d;
`endif

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    always_comb begin
        t_word   = ks.sub_out ^ ks.rcon_dout;
        w0_n     = wkey_q[127:96] ^ t_word;
        w1_n     = wkey_q[95:64]  ^ w0_n;
        w2_n     = wkey_q[63:32]  ^ w1_n;
        w3_n     = wkey_q[31:0]   ^ w2_n;
        next_key = {w0_n, w1_n, w2_n, w3_n};
    end

    // The next FETCH's ROM inputs are registered on the edge entering FETCH,
    // so they come from the key being written this cycle, not the stored one.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        wkey_d      = wkey_q;
        rcon_addr_d = rcon_addr_q;
        sub_in_d    = sub_in_q;
`ifdef KEY_SCHED_LAST_KEY_EN
        last_key_d  = last_key_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ks.start) begin
                    wkey_d  = ks.key_in;
                    round_d = 4'd1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                rcon_addr_d = round_q - 4'd1;
                sub_in_d    = rot_word(wkey_q[31:0]);
                state_d     = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_CALC;
            end
            S_CALC: begin
                wkey_d = next_key;
                if (round_q == LAST_ROUND) begin
`ifdef KEY_SCHED_LAST_KEY_EN
                    last_key_d = next_key;
`endif
                    state_d    = S_DONE;
                end else begin
                    round_d     = round_q + 4'd1;
                    rcon_addr_d = round_q;
                    sub_in_d    = rot_word(next_key[31:0]);
                    state_d     = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            round_q     <= 4'd0;
            wkey_q      <= 128'd0;
            rcon_addr_q <= 4'd0;
            sub_in_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            wkey_q      <= wkey_d;
            rcon_addr_q <= rcon_addr_d;
            sub_in_q    <= sub_in_d;
        end
    end

`ifdef KEY_SCHED_LAST_KEY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_key_q <= 128'd0;
        end else begin
            last_key_q <= last_key_d;
        end
    end

    assign ks.last_key = last_key_q;
`endif

    assign ks.busy      = (state_q == S_LOAD) || (state_q == S_FETCH) || (state_q == S_CALC);
    assign ks.done      = (state_q == S_DONE);
    assign ks.rk_we     = (state_q == S_LOAD) || (state_q == S_CALC);
    assign ks.rk_addr   = (state_q == S_CALC) ? round_q : 4'd0;
    assign ks.rk_data   = (state_q == S_CALC) ? next_key : wkey_q;
    assign ks.rcon_addr = rcon_addr_q;
    assign ks.sub_in    = sub_in_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Self-checking bench for key_sched_ctrl: FIPS-197 expansion model, registered ROM models,
// per-cycle output log compared against the expected run timeline.
module tb_key_sched_ctrl;

    logic clk;
    logic rst_n;
    int   cyc;
    int   base;
    int   cur;
    int   checks;
    int   errors;

    logic [7:0]   sbox [256];
    logic [127:0] exp_rk [11];

    logic         we_log   [2048];
    logic [3:0]   addr_log [2048];
    logic [127:0] data_log [2048];
    logic         done_log [2048];
    logic         busy_log [2048];
    logic [3:0]   rcon_log [2048];

    key_sched_if ifc ();

    key_sched_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [31:0] rcon_rom(input logic [3:0] a);
        case (a)
            4'd0: return 32'h01000000;
            4'd1: return 32'h02000000;
            4'd2: return 32'h04000000;
            4'd3: return 32'h08000000;
            4'd4: return 32'h10000000;
            4'd5: return 32'h20000000;
            4'd6: return 32'h40000000;
            4'd7: return 32'h80000000;
            4'd8: return 32'h1b000000;
            4'd9: return 32'h36000000;
            default: return 32'h00000000;
        endcase
    endfunction

    // Standard word-by-word FIPS-197 expansion; rcon derived by repeated xtime.
    function automatic void compute_model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                rc  = xtime(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic int li(input int c);
        return c % 2048;
    endfunction

    always @(posedge clk) begin
        ifc.rcon_dout <= rcon_rom(ifc.rcon_addr);
        ifc.sub_out   <= subword(ifc.sub_in);
    end

    always @(negedge clk) begin
        we_log[li(cyc)]   <= ifc.rk_we;
        addr_log[li(cyc)] <= ifc.rk_addr;
        data_log[li(cyc)] <= ifc.rk_data;
        done_log[li(cyc)] <= ifc.done;
        busy_log[li(cyc)] <= ifc.busy;
        rcon_log[li(cyc)] <= ifc.rcon_addr;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic start_run(input logic [127:0] key);
        ifc.key_in = key;
        ifc.start  = 1'b1;
        @(posedge clk);
        #1;
        base      = cyc;
        cur       = 1;
        ifc.start = 1'b0;
    endtask

    task automatic goto_cycle(input int k);
        while (cur < k) begin
            @(posedge clk);
            #1;
            cur++;
        end
    endtask

    // Cycle k of a run (k=1 is LOAD) is logged at index b+k-1.
    task automatic check_run(input int b, input logic [127:0] key, input string tag);
        int  n_we;
        int  ix;
        logic e_we;
        n_we = 0;
        compute_model(key);
        for (int k = 1; k <= 23; k++) begin
            ix   = li(b + k - 1);
            e_we = (k == 1) || ((k % 2 == 1) && (k >= 3) && (k <= 21));
            chk($sformatf("%s_we_c%0d", tag, k), 128'(we_log[ix]), 128'(e_we));
            chk($sformatf("%s_done_c%0d", tag, k), 128'(done_log[ix]), 128'(k == 22));
            chk($sformatf("%s_busy_c%0d", tag, k), 128'(busy_log[ix]), 128'((k >= 1) && (k <= 21)));
            if (we_log[ix] === 1'b1) n_we++;
            if (e_we) begin
                chk($sformatf("%s_addr_c%0d", tag, k), 128'(addr_log[ix]), 128'((k - 1) / 2));
                chk($sformatf("%s_data_c%0d", tag, k), data_log[ix], exp_rk[(k - 1) / 2]);
            end
            if ((k % 2 == 0) && (k <= 20))
                chk($sformatf("%s_rcon_c%0d", tag, k), 128'(rcon_log[ix]), 128'(k / 2 - 1));
        end
        chk($sformatf("%s_nwrites", tag), 128'(n_we), 128'(11));
`ifdef KEY_SCHED_LAST_KEY_EN
        chk($sformatf("%s_last_key", tag), ifc.last_key, exp_rk[10]);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      128'(ifc.busy),      128'(0));
        chk({tag, "_done"},      128'(ifc.done),      128'(0));
        chk({tag, "_rk_we"},     128'(ifc.rk_we),     128'(0));
        chk({tag, "_rk_addr"},   128'(ifc.rk_addr),   128'(0));
        chk({tag, "_rcon_addr"}, 128'(ifc.rcon_addr), 128'(0));
        chk({tag, "_sub_in"},    128'(ifc.sub_in),    128'(0));
`ifdef KEY_SCHED_LAST_KEY_EN
        chk({tag, "_last_key"},  ifc.last_key,        128'(0));
`endif
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] k;
        logic [127:0] k_other;
        int           n_bad;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] inv;
            logic [7:0] a;
            a   = 8'(i);
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, a);
            if (i == 0) inv = 8'h00;
            sbox[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        rst_n      = 1'b0;
        ifc.start  = 1'b0;
        ifc.key_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        start_run(k);
        goto_cycle(24);
        check_run(base, k, "fips");
        chk("fips_addr1_const",  data_log[li(base + 2)],  128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_addr10_const", data_log[li(base + 20)], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        k = '0;
        start_run(k);
        goto_cycle(24);
        check_run(base, k, "zero");
        chk("zero_addr0_const", data_log[li(base)],     128'h0);
        chk("zero_addr1_const", data_log[li(base + 2)], 128'h62636363626363636263636362636363);

        k = '1;
        start_run(k);
        goto_cycle(24);
        check_run(base, k, "ones");
        chk("ones_addr1_const", data_log[li(base + 2)], 128'he8e9e9e917161616e8e9e9e917161616);

        for (int r = 0; r < 4; r++) begin
            k = rand_key();
            start_run(k);
            goto_cycle(24);
            check_run(base, k, $sformatf("rand%0d", r));
        end

        // start retriggers and key_in change while a run is in flight
        k       = rand_key();
        k_other = rand_key();
        start_run(k);
        goto_cycle(3);
        ifc.key_in = k_other;
        goto_cycle(5);
        ifc.start = 1'b1;
        goto_cycle(6);
        ifc.start = 1'b0;
        goto_cycle(22);
        ifc.start = 1'b1;
        goto_cycle(23);
        ifc.start = 1'b0;
        goto_cycle(26);
        check_run(base, k, "noretrig");
        chk("noretrig_idle_c24", 128'(busy_log[li(base + 23)]), 128'(0));
        chk("noretrig_idle_c25", 128'(we_log[li(base + 24)]),   128'(0));

        // reset in cycle 9 of a run
        k = rand_key();
        start_run(k);
        goto_cycle(9);
        rst_n = 1'b0;
        goto_cycle(10);
        rst_n = 1'b1;
        check_reset_outputs("midrst");
        goto_cycle(31);
        n_bad = 0;
        for (int c = 10; c <= 30; c++) begin
            if (we_log[li(base + c - 1)] !== 1'b0)   n_bad++;
            if (done_log[li(base + c - 1)] !== 1'b0) n_bad++;
        end
        chk("midrst_no_activity", 128'(n_bad), 128'(0));
        k = rand_key();
        start_run(k);
        goto_cycle(24);
        check_run(base, k, "postrst");

        // start held high: runs repeat every 23 cycles
        k          = rand_key();
        ifc.key_in = k;
        ifc.start  = 1'b1;
        @(posedge clk);
        #1;
        base = cyc;
        cur  = 1;
        goto_cycle(69);
        ifc.start = 1'b0;
        goto_cycle(71);
        check_run(base,      k, "held0");
        check_run(base + 23, k, "held1");
        check_run(base + 46, k, "held2");
        chk("held_stop", 128'(busy_log[li(base + 69)]), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_sched_ctrl.md
# key_sched_ctrl

AES-128 key-expansion controller. It sequences the registered round-constant ROM (`rcon`) and an external registered SubWord unit to expand a 128-bit cipher key into 11 round keys. Each round key is written into the round-key store through a simple write port. It sits between the key-load interface and the cipher round datapath, and is started once per key change.

## Interface

Parameters: none.

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  request expansion; sampled only in IDLE
- `key_in`  in  128  cipher key; `[127:96]` = w0 … `[31:0]` = w3; captured on accepted start
- `busy`  out  1  high from LOAD through the last CALC
- `done`  out  1  one-cycle pulse after round key 10 is written
- `rcon_addr`  out  4  rcon ROM address; only values 0..9 are ever driven
- `rcon_dout`  in  32  rcon ROM data; valid one cycle after its address; constant in bits `[31:24]`, zeros below
- `sub_in`  out  32  word to SubWord unit
- `sub_out`  in  32  S-box applied to each byte of `sub_in`; valid one cycle after `sub_in`
- `rk_we`  out  1  round-key write strobe
- `rk_addr`  out  4  round-key index 0..10
- `rk_data`  out  128  round key, same word order as `key_in`

## Operation

- The state register holds one of IDLE, LOAD, FETCH, CALC or DONE. It also holds a 4-bit `round` counter and a 128-bit working key `w0..w3`.
- IDLE
  - With `start`=1: capture `key_in` into the working key, set `round`=1, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: `rk_we`=1, `rk_addr`=0, `rk_data`=working key (the captured key). Go to FETCH.
- FETCH
  - Drive `rcon_addr`=`round`−1 and `sub_in`=RotWord(w3)={w3[23:0],w3[31:24]}.
  - No write in this state. Go to CALC.
- CALC
  - `rcon_dout` and `sub_out` are valid in this cycle.
  - Compute t=`sub_out`^`rcon_dout`, then w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - Write the new key: `rk_we`=1, `rk_addr`=`round`, `rk_data`={w0',w1',w2',w3'}. The working key takes the new value at the clock edge.
  - If `round`=10, go to DONE. Otherwise increment `round` and go to FETCH.
- DONE: `done`=1, `busy`=0. Go to IDLE.
- `start` is ignored in every state except IDLE. A request in DONE is not accepted; it must be held or reissued in IDLE.
- `key_in` changes after acceptance have no effect on the run in progress.
- `rcon_addr` and `sub_in` hold their last driven values outside FETCH. Both ROMs are read-only, so extra reads are harmless.
- `rk_data` is don't-care when `rk_we`=0.

## Timing

- Latency
  - Start accepted at edge E0. LOAD occupies the cycle after E0 (cycle 1).
  - Round r: FETCH in cycle 2r, CALC in cycle 2r+1.
  - Round key 10 is written in cycle 21; `done` is high in cycle 22; IDLE from cycle 23.
  - Back-to-back: the earliest next start is sampled at the end of cycle 23.
- Round-key writes: exactly 11 `rk_we` pulses per run, at addresses 0,1,…,10 in order, never adjacent cycles after address 0.
- Outputs are decoded from registered state and registers only; there is no combinational path from inputs to outputs except `rk_data` from `sub_out`/`rcon_dout` during CALC.
- Reset (`rst_n`=0 at a rising edge), including mid-run:
  - state=IDLE, `round`=0, working key=0.
  - `busy`=0, `done`=0, `rk_we`=0, `rk_addr`=0, `rcon_addr`=0, `sub_in`=0.
  - A run aborted by reset produces no further writes and no `done`.
- Counter `round` is 4 bits and never exceeds 10; it does not wrap.

## Configuration

- `KEY_SCHED_LAST_KEY_EN`
  - Defined: adds output port `last_key` [127:0]. It loads round key 10 in the final CALC cycle and holds it until the next completed run or reset (reset value 0). This gives the decryption path its starting key without reading the store.
  - Undefined: the port and register are absent; all other behaviour is identical.

## Test plan

- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`, start pulse -> 11 writes; addr1=`a0fafe1788542cb123a339392a6c7605`, addr10=`d014f9a8c9ee2589e13f0cc8b6630ca6`; `done` in cycle 22.
- All-zero key -> addr0=0, addr1=`62636363626363636263636362636363`; `rcon_addr` sequence 0..9 in FETCH cycles.
- All-ones key -> addr1=`e8e9e9e917161616e8e9e9e917161616`; with `KEY_SCHED_LAST_KEY_EN` defined, `last_key` equals addr10 data after `done`.
- Start pulsed again in cycles 5 and 22, and `key_in` changed in cycle 3 -> no restart, results identical to the first run.
- `rst_n` low in cycle 9 -> all outputs at reset values next cycle, no further `rk_we` or `done`; a new start afterwards completes normally.
- `start` held high continuously -> runs repeat with `done` every 23 cycles, each run writing 11 keys.
